// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI mode-0 slave that turns 32-bit frames into register-bus cycles.
// Optional abort counter output o_err_cnt is built when SPI_SLAVE_ERR_CNT_EN is defined.
module spi_slave_if #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_miso_oe,
    output logic [15:0] o_addr,
    output logic [15:0] o_wdata,
    output logic        o_wr,
    input  logic [15:0] i_rdata,
    output logic        o_busy
`ifdef SPI_SLAVE_ERR_CNT_EN
    ,
    output logic [7:0]  o_err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        RDATA,
        WDATA,
        DONE
    } state_t;

    localparam logic [2:0] LAT_END = 3'(RD_LAT);

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, fill;
    logic                   sclk_q;
    logic                   sclk_s, cs_s, mosi_s, fill_done;
    logic                   rise, fall;
    logic                   armed;
    logic [5:0]             bit_cnt;
    logic [2:0]             lat_cnt;
    logic [14:0]            rx;
    logic [14:0]            tx;
    logic                   abort, do_addr, do_load, do_wr;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign fill_done = fill[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_q;
    assign fall      = ~sclk_s & sclk_q;

    // fill tracks when the chains hold real pad samples rather than reset values,
    // so a cs_n held low across reset is never mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_q    <= sclk_s;
        end
    end

    always_comb begin
        state_n = state;
        abort   = 1'b0;
        do_addr = 1'b0;
        do_load = 1'b0;
        do_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !cs_s) state_n = CMD;
            end
            CMD: begin
                if (cs_s) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (rise && bit_cnt == 6'd15) begin
                    do_addr = 1'b1;
                    state_n = rx[14] ? WDATA : FETCH;
                end
            end
            FETCH: begin
                if (cs_s) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (lat_cnt == LAT_END) begin
                    do_load = 1'b1;
                    state_n = RDATA;
                end
            end
            // The 32nd rise wins over a coincident cs_n rise.
            RDATA: begin
                if (rise && bit_cnt == 6'd31) begin
                    state_n = DONE;
                end else if (cs_s) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            WDATA: begin
                if (rise && bit_cnt == 6'd31) begin
                    do_wr   = 1'b1;
                    state_n = DONE;
                end else if (cs_s) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            DONE: begin
                if (cs_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            lat_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            o_miso    <= 1'b0;
            o_miso_oe <= 1'b0;
            o_addr    <= '0;
            o_wdata   <= '0;
            o_wr      <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state  <= state_n;
            o_busy <= (state_n != IDLE);
            o_wr   <= do_wr;

            if (state != IDLE)          armed <= 1'b0;
            else if (fill_done && cs_s) armed <= 1'b1;

            if (state == IDLE)                 bit_cnt <= '0;
            else if (rise && state != DONE)    bit_cnt <= bit_cnt + 6'd1;

            if (state == FETCH) lat_cnt <= lat_cnt + 3'd1;
            else                lat_cnt <= '0;

            if (rise && (state == CMD || state == WDATA)) rx <= {rx[13:0], mosi_s};

            if (do_addr) o_addr  <= {1'b0, rx[13:0], mosi_s};
            if (do_wr)   o_wdata <= {rx[14:0], mosi_s};

            // The fall right after the 16th rise keeps rdata[15] on the line:
            // shifting starts only once the master has sampled it.
            if (do_load) begin
                tx        <= i_rdata[14:0];
                o_miso    <= i_rdata[15];
                o_miso_oe <= 1'b1;
            end else if (state == RDATA && fall && bit_cnt > 6'd16) begin
                tx     <= {tx[13:0], 1'b0};
                o_miso <= tx[14];
            end

            if (state_n == IDLE || state_n == DONE) begin
                o_miso    <= 1'b0;
                o_miso_oe <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err_cnt <= '0;
        end else if (abort && (bit_cnt != 6'd0 || rise) && o_err_cnt != 8'hFF) begin
            o_err_cnt <= o_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - randomized frame-level bench for spi_slave_if with a register-file model.
module tb_spi_slave_if;

    localparam int SYNC_STAGES = 2;
    localparam int RD_LAT      = 2;
    localparam logic [15:0] INIT [0:15] = '{
        16'h1111, 16'h2222, 16'h0001, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888,
        16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hF0F0, 16'h0F0F
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, wr, busy;
    logic [15:0] addr, wdata, rdata;
`ifdef SPI_SLAVE_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    spi_slave_if #(.SYNC_STAGES(SYNC_STAGES), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sclk    (sclk),
        .i_cs_n    (cs_n),
        .i_mosi    (mosi),
        .o_miso    (miso),
        .o_miso_oe (miso_oe),
        .o_addr    (addr),
        .o_wdata   (wdata),
        .o_wr      (wr),
        .i_rdata   (rdata),
        .o_busy    (busy)
`ifdef SPI_SLAVE_ERR_CNT_EN
        ,
        .o_err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Environment register file: 16 words, read data appears RD_LAT cycles after addr.
    logic [15:0] mem [0:15] = INIT;
    logic [15:0] addr_d [0:RD_LAT-1];
    always @(posedge clk) begin
        addr_d[0] <= addr;
        for (int k = 1; k < RD_LAT; k++) addr_d[k] <= addr_d[k-1];
        if (wr && addr < 16'd16) mem[addr[3:0]] <= wdata;
    end
    always_comb begin
        rdata = 16'h0000;
        if (addr_d[RD_LAT-1] < 16'd16) rdata = mem[addr_d[RD_LAT-1][3:0]];
    end

    int          tests = 0;
    int          fails = 0;
    int          wr_cnt = 0;
    int          wr_long = 0;
    bit          wr_prev = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;

    always @(negedge clk) begin
        if (wr) begin
            wr_cnt++;
            wr_addr = addr;
            wr_data = wdata;
            if (wr_prev) wr_long++;
        end
        wr_prev = wr;
    end

    // Reference model state
    logic [15:0] ref_mem [0:15] = INIT;
    logic [15:0] exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    int          exp_err = 0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return (a < 16'd16) ? ref_mem[a[3:0]] : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [31:0] word, input int nbits, input int extra,
                             input bit cs_last, input int rst_at);
        int          h;
        int          wr0;
        int          oe_bad;
        int          miso_bad;
        int          exp_wr;
        bit          is_rd;
        bit          did_rst;
        logic        exp_oe;
        logic [31:0] rxw;
        logic [15:0] a;
        h        = $urandom_range(8, 11);
        wr0      = wr_cnt;
        oe_bad   = 0;
        miso_bad = 0;
        exp_wr   = 0;
        is_rd    = !word[31];
        did_rst  = 1'b0;
        rxw      = '0;
        a        = {1'b0, word[30:16]};

        cs_n = 1'b0;
        wait_clk(h);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[31-i];
            wait_clk(h);
            rxw[31-i] = miso;
            exp_oe = is_rd && i >= 16 && !did_rst;
            if (miso_oe !== exp_oe) oe_bad++;
            if (!is_rd && miso !== 1'b0) miso_bad++;
            if (i == 8 && !did_rst) check("busy_mid", busy, 1);
            sclk = 1'b1;
            if (cs_last && i == nbits - 1) cs_n = 1'b1;
            wait_clk(h);
            sclk = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                wait_clk(3);
                check("rst_addr", addr, 0);
                check("rst_wdata", wdata, 0);
                check("rst_busy", busy, 0);
                check("rst_oe", {miso_oe, miso}, 0);
                rst       = 1'b0;
                did_rst   = 1'b1;
                exp_addr  = '0;
                exp_wdata = '0;
                exp_err   = 0;
            end
        end
        for (int j = 0; j < extra; j++) begin
            mosi = 1'($urandom);
            wait_clk(h);
            if (miso !== 1'b0 || miso_oe !== 1'b0) miso_bad++;
            sclk = 1'b1;
            wait_clk(h);
            sclk = 1'b0;
        end
        wait_clk(h);
        cs_n = 1'b1;
        wait_clk(4 * h);

        if (!did_rst) begin
            if (nbits == 32) begin
                exp_addr = a;
                if (!is_rd) begin
                    exp_wr    = 1;
                    exp_wdata = word[15:0];
                    if (a < 16'd16) ref_mem[a[3:0]] = word[15:0];
                end else begin
                    check("rd_data", rxw[15:0], ref_rd(a));
                end
            end else begin
                if (nbits >= 16) exp_addr = a;
                if (nbits >= 1 && exp_err < 255) exp_err++;
            end
        end

        check("wr_count", wr_cnt - wr0, exp_wr);
        if (exp_wr == 1) begin
            check("wr_addr", wr_addr, exp_addr);
            check("wr_data", wr_data, exp_wdata);
        end
        check("addr", addr, exp_addr);
        check("wdata", wdata, exp_wdata);
        check("busy_idle", busy, 0);
        check("oe_idle", {miso_oe, miso}, 0);
        check("oe_phase", oe_bad, 0);
        check("miso_quiet", miso_bad, 0);
`ifdef SPI_SLAVE_ERR_CNT_EN
        check("err_cnt", err_cnt, exp_err);
`endif
    endtask

    initial begin
        int          nb;
        int          ex;
        bit          cl;
        logic [31:0] w;

        wait_clk(4);
        check("reset_outs", {miso, miso_oe, wr, busy}, 0);
        check("reset_addr", addr, 0);
        check("reset_wdata", wdata, 0);
`ifdef SPI_SLAVE_ERR_CNT_EN
        check("reset_err", err_cnt, 0);
`endif
        rst = 1'b0;
        wait_clk(10);

        spi_frame(32'h8000_1234, 32, 0, 1'b0, -1);
        spi_frame(32'h0002_0000, 32, 0, 1'b0, -1);
        spi_frame(32'h8001_0001, 20, 0, 1'b0, -1);
        spi_frame(32'h0001_0000, 32, 0, 1'b0, -1);
        spi_frame(32'h8003_ABCD, 32, 8, 1'b0, -1);
        spi_frame(32'h0003_0000, 32, 0, 1'b0, -1);
        spi_frame(32'h8004_5555, 32, 0, 1'b0, 10);
        spi_frame(32'h8005_0F0F, 32, 0, 1'b0, -1);
        spi_frame(32'h8000_00FF, 32, 0, 1'b0, -1);
        spi_frame(32'h0000_0000, 32, 0, 1'b0, -1);
        spi_frame(32'h8006_BEEF, 32, 0, 1'b1, -1);
        spi_frame(32'h0006_0000, 32, 0, 1'b1, -1);
        spi_frame(32'h8007_1357, 0, 0, 1'b0, -1);
        spi_frame(32'h0013_0000, 32, 0, 1'b0, -1);

        for (int n = 0; n < 14; n++) begin
            w = {1'($urandom), 15'($urandom_range(0, 20)), 16'($urandom)};
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 32;
            ex = (nb == 32) ? $urandom_range(0, 3) : 0;
            cl = (nb == 32 && ex == 0) ? 1'($urandom) : 1'b0;
            spi_frame(w, nb, ex, cl, -1);
        end

        check("wr_width", wr_long, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front end that sits directly upstream of the register file.
- Oversamples SCLK, CS_N and MOSI in the system clock domain and decodes 32-bit frames into register-bus cycles (address, write data, write strobe).
- For read frames, fetches register read data and shifts it back out on MISO.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on i_sclk, i_cs_n and i_mosi; legal range 2..4.
- RD_LAT, 2: clk cycles from an o_addr update to valid i_rdata; legal range 1..4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- i_sclk  input  1  SPI serial clock, asynchronous to clk.
- i_cs_n  input  1  SPI chip select, active low, asynchronous.
- i_mosi  input  1  SPI master-out data, asynchronous.
- o_miso  output  1  SPI slave-out data.
- o_miso_oe  output  1  MISO output enable; drives the pad tristate.
- o_addr  output  16  register address to the register file.
- o_wdata  output  16  register write data.
- o_wr  output  1  write strobe, one-cycle pulse.
- i_rdata  input  16  register read data, valid RD_LAT cycles after o_addr changes.
- o_busy  output  1  high while a frame is in progress (cs_n low, synchronised).

Behaviour:
- Reset: synchronous, active-high, clk domain only. All outputs 0: o_miso, o_miso_oe, o_addr, o_wdata, o_wr, o_busy.
  - Synchroniser flops reset to idle levels: sclk=0, cs_n=1, mosi=0.
  - FSM goes to IDLE.
- Frame format, 32 bits, MSB first:
  - bit31: W (1=write, 0=read).
  - bits30:16: address A[14:0]; o_addr = {1'b0, A}.
  - bits15:0: data (write) or don't-care (read).
- Edge detection: rise/fall flags come from the last two synchronised sclk samples. MOSI is sampled on the rise flag.
- Timing constraint: SCLK high and low phases each >= SYNC_STAGES+RD_LAT+3 clk cycles. The bench must honour it; the DUT does not check it.
- Bit counter: 6 bits, cleared on entry to CMD, incremented on each rise flag.
- FSM states:
  - IDLE:
    - Synchronised cs_n falling edge -> CMD; o_busy=1.
    - If cs_n is already low when rst releases, stay in IDLE until cs_n has been seen high.
  - CMD: shift in bits 31..16.
    - On the 16th rise: latch o_addr next cycle.
    - W=1 -> WDATA.
    - W=0 -> FETCH.
  - FETCH:
    - Wait RD_LAT cycles after the o_addr update, then load the 16-bit tx shift register from i_rdata.
    - o_miso_oe=1, o_miso=rdata[15] in the same cycle -> RDATA.
  - RDATA:
    - On each fall flag, shift tx left; o_miso = next bit.
    - After the 32nd rise -> DONE.
    - o_miso_oe stays 1 until DONE.
  - WDATA:
    - Shift in bits 15..0.
    - On the 32nd rise, the next cycle sets o_wdata = shifted data and o_wr=1 for exactly one cycle -> DONE.
  - DONE:
    - o_miso_oe=0, o_miso=0.
    - Further sclk edges are ignored; there is no second frame without cs_n going high.
    - cs_n high -> IDLE; o_busy=0.
- Abort: cs_n rises in CMD, FETCH, RDATA or WDATA -> IDLE the next cycle.
  - No o_wr pulse; o_miso_oe=0.
  - o_addr and o_wdata hold their last values.
- cs_n rise coincident with the 32nd rise flag: the frame counts as complete and o_wr is still issued. The cs_n edge has priority only for bit counts below 32.
- o_addr and o_wdata are stable whenever o_wr=1 and change only as described above.
- Read frame with an address outside the register file returns whatever i_rdata presents (0 from the register file).
- Reset asserted mid-frame: immediate return to reset state, no o_wr. The rest of the frame is ignored per the IDLE rule.

Optional Feature:
- Macro: SPI_SLAVE_ERR_CNT_EN.
- Defined:
  - Adds output o_err_cnt [7:0], reset 0.
  - Increments by 1 on every aborted frame (cs_n high with bit count 1..31).
  - Saturates at 255; cleared only by rst.
  - A frame with bit count 0 (cs_n pulse with no sclk) does not count.
- Undefined: no port; aborts are silently discarded.

Test Plan:
- Write frame 0x8000_1234 (W=1, addr 0) -> o_addr=0x0000, o_wdata=0x1234, single-cycle o_wr pulse after the 32nd SCLK rise; o_miso_oe stays 0.
- Read frame 0x0002_0000, i_rdata model returns 0x0001 for addr 2 after RD_LAT -> o_addr=0x0002; MISO bits 16..31 = 0x0001 MSB first; o_miso_oe high only in the data phase; o_wr never asserted.
- Write frame 0x8001_0001 aborted by cs_n high after 20 bits -> no o_wr; FSM in IDLE; a following full read of addr 1 completes correctly; with SPI_SLAVE_ERR_CNT_EN, o_err_cnt=1.
- Write frame followed by 8 extra SCLK pulses before cs_n rises -> exactly one o_wr with data from bits 15..0; extra pulses ignored; o_miso stays 0.
- rst asserted at bit 10 of a write frame with cs_n held low -> outputs return to 0; no o_wr; block ignores that frame and accepts the next frame only after cs_n goes high then low.
- Back-to-back: write 0x8000_00FF, cs_n high for 2 SCLK periods, then read 0x0000_0000 returning 0x00FF -> MISO shifts 0x00FF; o_busy drops between frames.
